pld_link_rx: RTL and testbench

- Consumer end of the 16-bit rts/cts word link that the capture FPGA drives toward the host-side bridge.
- Samples words offered by a sender on an asynchronous 4-phase rts/cts handshake and buffers them in a FIFO.
- Presents the buffered words as a valid/ready stream to local logic.
- Used on the host-bridge side and as the loopback sink in link bring-up builds.

---
 rtl/pld_link_rx_if.sv | 39 +++
 rtl/pld_link_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_pld_link_rx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pld_link_rx_if.sv
// pld_link_rx_if
//   Groups the two faces of the link receiver: the sender-side 4-phase
//   rts/cts word link and the downstream valid/ready word stream.
//   Signals:
//     rts        sender request (asynchronous to the receiver clock)
//     data_in    16-bit sender word, stable while rts is high until cts
//     cts        acknowledge back to the sender
//     data_out   head-of-FIFO word (show-ahead)
//     data_valid receiver holds at least one word
//     data_ready downstream accepts data_out this cycle
//   Modports:
//     slave  - the receiver (pld_link_rx)
//     master - the environment: sender plus downstream consumer
interface pld_link_rx_if;
  logic        rts;
  logic [15:0] data_in;
  logic        cts;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;

  modport slave (
    input  rts,
    input  data_in,
    input  data_ready,
    output cts,
    output data_out,
    output data_valid
  );

  modport master (
    output rts,
    output data_in,
    output data_ready,
    input  cts,
    input  data_out,
    input  data_valid
  );
endinterface

// File: rtl/pld_link_rx.sv
// pld_link_rx
//   Consumer end of the 16-bit rts/cts word link. Words offered by an
//   asynchronous sender are sampled once per 4-phase handshake, buffered in
//   a show-ahead FIFO and presented downstream as a valid/ready stream.
//   Ports:
//     clk         receiver clock, all state on the rising edge
//     reset       asynchronous active-low reset
//     link        pld_link_rx_if.slave (rts, data_in, cts, data_out,
//                 data_valid, data_ready)
//     fifo_count  words currently held (0..DEPTH)
//     word_count  words accepted since reset, wraps at 2^32
//     stall_err   sticky: sender kept rts high TIMEOUT cycles past cts
module pld_link_rx #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  pld_link_rx_if.slave      link,
  output logic [ADDR_W:0]   fifo_count,
  output logic [31:0]       word_count,
  output logic              stall_err
);

  localparam int                CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ZERO  = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Synchronizer, FSM and FIFO state
  logic              r_rts_meta;
  logic              r_rts_sync;
  state_t            r_state;
  logic              r_cts;
  logic [15:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_word_count;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_stall_err;

  // Combinational decisions
  state_t            w_state_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_cts_nxt;
  logic              w_stall_hit;

  assign w_full = (r_count == DEPTH_C);
  // Pop only when something is held; a pop request on an empty FIFO is dropped.
  assign w_pop  = link.data_ready && (r_count != LVL_ZERO);

  // Two-flop synchronizer bringing the asynchronous rts into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rts_meta <= 1'b0;
      r_rts_sync <= 1'b0;
    end else begin
      r_rts_meta <= link.rts;
      r_rts_sync <= r_rts_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; the push decision is only ever taken in IDLE while
  // the FIFO has room, which is what makes a push+pop at full safe.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_rts_sync && !w_full) begin
          w_state_nxt = ST_ACK;
          w_push      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_push      = 1'b0;
        end
      end
      ST_ACK: begin
        if (!r_rts_sync) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_DONE: begin
        // One forced cts-low cycle before the next word can be taken.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_push      = 1'b0;
      end
    endcase
  end

  // FSM output decode: cts request and the stall-timeout condition.
  always_comb begin
    w_cts_nxt   = 1'b0;
    w_stall_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cts_nxt   = 1'b0;
        w_stall_hit = 1'b0;
      end
      ST_ACK: begin
        w_cts_nxt   = 1'b1;
        w_stall_hit = (r_stall_cnt == TIMEOUT_C);
      end
      ST_DONE: begin
        w_cts_nxt   = 1'b0;
        w_stall_hit = 1'b0;
      end
      default: begin
        w_cts_nxt   = 1'b0;
        w_stall_hit = 1'b0;
      end
    endcase
  end

  // Registered cts toward the sender (lags the FSM state by one cycle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cts <= 1'b0;
    end else begin
      r_cts <= w_cts_nxt;
    end
  end

  // Stall counter: cleared on entering ACK, counts while rts is held, saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= CNT_ZERO;
    end else if (w_push) begin
      r_stall_cnt <= CNT_ZERO;
    end else if ((r_state == ST_ACK) && r_rts_sync && (r_stall_cnt != TIMEOUT_C)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  // Sticky stall error; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_err <= 1'b0;
    end else if (w_stall_hit) begin
      r_stall_err <= 1'b1;
    end else begin
      r_stall_err <= r_stall_err;
    end
  end

  // FIFO storage write; contents need no reset because validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= link.data_in;
    end
  end

  // FIFO pointers; DEPTH is a power of two so natural overflow wraps them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= LVL_ZERO;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_ONE;
        2'b01:   r_count <= r_count - LVL_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Accepted-word counter, free-running modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_count <= 32'd0;
    end else if (w_push) begin
      r_word_count <= r_word_count + 32'd1;
    end else begin
      r_word_count <= r_word_count;
    end
  end

  assign link.cts        = r_cts;
  assign link.data_out   = r_mem[r_rd_ptr];
  assign link.data_valid = (r_count != LVL_ZERO);
  assign fifo_count      = r_count;
  assign word_count      = r_word_count;
  assign stall_err       = r_stall_err;

endmodule

// File: tb/tb_pld_link_rx.sv
module tb_pld_link_rx;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W:0]   fifo_count;
  logic [31:0]       word_count;
  logic              stall_err;

  pld_link_rx_if link_if();

  pld_link_rx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .link       (link_if),
    .fifo_count (fifo_count),
    .word_count (word_count),
    .stall_err  (stall_err)
  );

  always #5 clk = ~clk;

  // Reference model: words offered but not yet seen downstream, in order,
  // and the number of words the receiver should have accepted since reset.
  int          total = 0;
  int          bad   = 0;
  logic [15:0] sent_q[$];
  int unsigned exp_words = 0;
  int          ready_mode = 0;   // 0 = hold low, 1 = hold high, 2 = random

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready driver, updated 2 time units after each rising edge.
  initial begin
    link_if.data_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       link_if.data_ready = 1'b0;
        1:       link_if.data_ready = 1'b1;
        default: link_if.data_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Downstream monitor: every word consumed must be the oldest word offered.
  always @(negedge clk) begin
    if (reset === 1'b1 && link_if.data_valid === 1'b1 && link_if.data_ready === 1'b1) begin
      if (sent_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL pop_unexpected observed=%0h expected=none", link_if.data_out);
      end else begin
        check("pop_data", {16'd0, link_if.data_out}, {16'd0, sent_q.pop_front()});
      end
    end
  end

  task automatic wait_cts(input logic v, input int budget, input string tag);
    int n = 0;
    while (link_if.cts !== v && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, link_if.cts}, {31'd0, v});
  endtask

  task automatic offer(input logic [15:0] w);
    link_if.data_in = w;
    link_if.rts     = 1'b1;
    sent_q.push_back(w);
    exp_words++;
  endtask

  task automatic send_word(input logic [15:0] w);
    offer(w);
    wait_cts(1'b1, 200, "cts_rise");
    link_if.rts = 1'b0;
    wait_cts(1'b0, 20, "cts_fall");
  endtask

  // Only meaningful with the sender idle and ready held low.
  task automatic check_idle(input string tag);
    check({tag, "_count"}, 32'(fifo_count), sent_q.size());
    check({tag, "_valid"}, {31'd0, link_if.data_valid}, {31'd0, (sent_q.size() != 0)});
    check({tag, "_words"}, word_count, exp_words);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    ready_mode = 1;
    while (sent_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    ready_mode = 0;
    tick();
    tick();
    check_idle(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    reset           = 1'b0;
    link_if.rts     = 1'b0;
    link_if.data_in = 16'd0;
    #2;
    check("rst_cts",   {31'd0, link_if.cts},        32'd0);
    check("rst_valid", {31'd0, link_if.data_valid}, 32'd0);
    check("rst_count", 32'(fifo_count),             32'd0);
    check("rst_words", word_count,                  32'd0);
    check("rst_stall", {31'd0, stall_err},          32'd0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    tick();

    // Single word with exact latency checks.
    offer(16'hA5C3);
    tick();
    tick();
    check("sw_count_n1", 32'(fifo_count), 32'd0);
    tick();
    check("sw_count_n2", 32'(fifo_count), 32'd1);
    check("sw_cts_n2",   {31'd0, link_if.cts}, 32'd0);
    check("sw_data",     {16'd0, link_if.data_out}, 32'h0000A5C3);
    check("sw_valid",    {31'd0, link_if.data_valid}, 32'd1);
    check("sw_words",    word_count, 32'd1);
    tick();
    check("sw_cts_n3",   {31'd0, link_if.cts}, 32'd1);
    link_if.rts = 1'b0;
    repeat (3) tick();
    check("sw_cts_m2",   {31'd0, link_if.cts}, 32'd1);
    tick();
    check("sw_cts_m3",   {31'd0, link_if.cts}, 32'd0);
    check_idle("sw");
    drain("sw_drain");

    // 64 words back to back with downstream always ready.
    ready_mode = 1;
    for (int i = 1; i <= 64; i++) begin
      send_word(16'(i));
    end
    drain("b2b");
    check("b2b_stall", {31'd0, stall_err}, 32'd0);

    // Fill to DEPTH, then a 17th word must be held off until a pop.
    for (int i = 0; i < DEPTH; i++) begin
      send_word(16'($urandom));
    end
    check("bp_full", 32'(fifo_count), DEPTH);
    offer(16'($urandom));
    repeat (12) tick();
    check("bp_cts_low", {31'd0, link_if.cts}, 32'd0);
    check("bp_count",   32'(fifo_count), DEPTH);
    check("bp_words",   word_count, exp_words - 1);
    check("bp_head",    {16'd0, link_if.data_out}, {16'd0, sent_q[0]});
    ready_mode = 1;
    tick();
    ready_mode = 0;
    wait_cts(1'b1, 20, "bp_cts_rise");
    link_if.rts = 1'b0;
    wait_cts(1'b0, 20, "bp_cts_fall");
    tick();
    check("bp_refull", 32'(fifo_count), DEPTH);
    check_idle("bp");
    drain("bp_drain");

    // Push and pop in the same cycle at fifo_count = 5.
    for (int i = 0; i < 5; i++) begin
      send_word(16'($urandom));
    end
    tick();
    check("pp_pre", 32'(fifo_count), 32'd5);
    offer(16'($urandom));
    tick();
    tick();
    ready_mode = 1;
    tick();
    ready_mode = 0;
    check("pp_count", 32'(fifo_count), 32'd5);
    check("pp_words", word_count, exp_words);
    wait_cts(1'b1, 20, "pp_cts_rise");
    link_if.rts = 1'b0;
    wait_cts(1'b0, 20, "pp_cts_fall");
    tick();
    check_idle("pp");
    drain("pp_drain");

    // Random data, random gaps, random downstream ready.
    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_word(16'($urandom));
    end
    drain("rnd");
    check("rnd_stall", {31'd0, stall_err}, 32'd0);

    // Sender never drops rts: stall_err 8 cycles after cts rises.
    ready_mode = 1;
    offer(16'($urandom));
    repeat (4) tick();
    check("to_cts_up", {31'd0, link_if.cts}, 32'd1);
    repeat (7) tick();
    check("to_stall_early", {31'd0, stall_err}, 32'd0);
    tick();
    check("to_stall_set", {31'd0, stall_err}, 32'd1);
    check("to_cts_hold",  {31'd0, link_if.cts}, 32'd1);
    repeat (5) tick();
    check("to_cts_hold2", {31'd0, link_if.cts}, 32'd1);
    link_if.rts = 1'b0;
    wait_cts(1'b0, 20, "to_cts_fall");
    repeat (3) tick();
    check("to_stall_sticky", {31'd0, stall_err}, 32'd1);
    drain("to_drain");

    // Reset in ACK with 3 words buffered, rts still high at release.
    send_word(16'($urandom));
    send_word(16'($urandom));
    w = 16'($urandom);
    offer(w);
    wait_cts(1'b1, 20, "rm_cts_rise");
    check("rm_pre_count", 32'(fifo_count), 32'd3);
    reset = 1'b0;
    #1;
    sent_q.delete();
    exp_words = 0;
    check("rm_cts",   {31'd0, link_if.cts},        32'd0);
    check("rm_count", 32'(fifo_count),             32'd0);
    check("rm_valid", {31'd0, link_if.data_valid}, 32'd0);
    check("rm_words", word_count,                  32'd0);
    check("rm_stall", {31'd0, stall_err},          32'd0);
    tick();
    tick();
    reset = 1'b1;
    sent_q.push_back(w);
    exp_words = 1;
    wait_cts(1'b1, 20, "rm_cts_again");
    check("rm_words1", word_count, 32'd1);
    check("rm_count1", 32'(fifo_count), 32'd1);
    check("rm_data",   {16'd0, link_if.data_out}, {16'd0, w});
    link_if.rts = 1'b0;
    wait_cts(1'b0, 20, "rm_cts_fall");
    drain("rm_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
